ctrl_decode_queue: RTL and testbench

- Registered successor to the ID-stage combinational control decoder.
- Decodes mode/op_code/s/cond and evaluates the ARM condition against the NZCV status flags.
- Pushes the resulting control word plus a passthrough tag into a parametrised queue feeding ID/EX.
- Adds valid/ready handshake, stall buffering, flush, and illegal-encoding detection.

---
 rtl/ctrl_decode_queue_pkg.sv | 96 +++++++++
 rtl/ctrl_decode_queue_if.sv | 36 +++
 rtl/ctrl_decode_queue_cond_check.sv | 34 +++
 rtl/ctrl_decode_queue.sv | 110 +++++++++++
 tb/tb_ctrl_decode_queue.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_decode_queue_pkg.sv
// Shared encodings and decode helper for ctrl_decode_queue.
package ctrl_pkg;

    // ALU command encodings presented to EX
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Data-processing opcode field
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [1:0] {
        MODE_ALU  = 2'b00,
        MODE_MEM  = 2'b01,
        MODE_BR   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       s;
        logic       b;
        logic       illegal;
    } ctrl_word_t;

    // Unconditional decode of the instruction fields into a control word
    function automatic ctrl_word_t decode_ctrl(input logic [1:0] mode,
                                               input logic [3:0] op_code,
                                               input logic       s_in);
        ctrl_word_t w;
        w = '0;
        case (mode)
            MODE_ALU: begin
                w.wb_en = 1'b1;
                w.s     = s_in;
                case (op_code)
                    OP_MOV: w.exe_cmd = EXE_MOV;
                    OP_MVN: w.exe_cmd = EXE_MVN;
                    OP_ADD: w.exe_cmd = EXE_ADD;
                    OP_ADC: w.exe_cmd = EXE_ADC;
                    OP_SUB: w.exe_cmd = EXE_SUB;
                    OP_SBC: w.exe_cmd = EXE_SBC;
                    OP_AND: w.exe_cmd = EXE_AND;
                    OP_ORR: w.exe_cmd = EXE_ORR;
                    OP_EOR: w.exe_cmd = EXE_EOR;
                    OP_CMP: begin w.exe_cmd = EXE_SUB; w.wb_en = 1'b0; end
                    OP_TST: begin w.exe_cmd = EXE_AND; w.wb_en = 1'b0; end
                    default: begin w = '0; w.illegal = 1'b1; end
                endcase
            end
            MODE_MEM: begin
                w.exe_cmd = EXE_ADD;
                if (s_in) begin
                    w.mem_r_en = 1'b1;
                    w.wb_en    = 1'b1;
                end else begin
                    w.mem_w_en = 1'b1;
                end
            end
            MODE_BR: begin
                w.b       = 1'b1;
                w.exe_cmd = EXE_NOP;
            end
            default: w.illegal = 1'b1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode_queue_if.sv
// Instruction-in / control-out handshake bundle for ctrl_decode_queue.
// master: the surrounding pipeline; slave: the decode queue.
interface ctrl_decode_queue_if #(
    parameter int EXE_CMD_W = 4,
    parameter int TAG_W     = 32
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           mode;
    logic [3:0]           op_code;
    logic                 s_in;
    logic [3:0]           cond;
    logic [3:0]           status;
    logic [TAG_W-1:0]     tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 wb_en;
    logic                 s;
    logic                 b;
    logic                 illegal;
    logic [TAG_W-1:0]     tag_out;

    modport master (
        output flush, in_valid, mode, op_code, s_in, cond, status, tag_in, out_ready,
        input  in_ready, out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, illegal, tag_out
    );

    modport slave (
        input  flush, in_valid, mode, op_code, s_in, cond, status, tag_in, out_ready,
        output in_ready, out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, illegal, tag_out
    );
endinterface

// File: rtl/ctrl_decode_queue_cond_check.sv
// ARM condition-code evaluation against NZCV flags (bit3=N .. bit0=V).
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = status;

    // Map each condition code to its flag predicate; NV never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/ctrl_decode_queue.sv
// Registered ID-stage control decoder with a DEPTH-entry queue to ID/EX.
// Optional macro CTRL_DECODE_PERF_EN adds saturating issue/squash counters.
module ctrl_decode_queue
    import ctrl_pkg::*;
#(
    parameter int EXE_CMD_W = 4,
    parameter int TAG_W     = 32,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ctrl_decode_queue_if.slave   bus
`ifdef CTRL_DECODE_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_squashed
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    ctrl_word_t       mem_word [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             cond_pass;
    logic             push, pop;
    ctrl_word_t       dec_word, push_word, head_word;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    cond_check u_cond_check (
        .cond   (bus.cond),
        .status (bus.status),
        .pass   (cond_pass)
    );

    assign bus.in_ready  = !bus.flush && ((count < CNT_FULL) || bus.out_ready);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

    // Decode, then squash controls on a failed condition (illegal survives)
    always_comb begin
        dec_word  = decode_ctrl(bus.mode, bus.op_code, bus.s_in);
        push_word = dec_word;
        if (!cond_pass) begin
            push_word         = '0;
            push_word.illegal = dec_word.illegal;
        end
    end

    // Queue storage; contents are don't-care while count is 0
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= push_word;
            mem_tag[wr_ptr]  <= bus.tag_in;
        end
    end

    // Pointer and occupancy tracking; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head entry drives the outputs, forced to zero when empty
    always_comb begin
        head_word   = bus.out_valid ? mem_word[rd_ptr] : '0;
        bus.tag_out = bus.out_valid ? mem_tag[rd_ptr] : '0;
        bus.exe_cmd  = EXE_CMD_W'(head_word.exe_cmd);
        bus.mem_r_en = head_word.mem_r_en;
        bus.mem_w_en = head_word.mem_w_en;
        bus.wb_en    = head_word.wb_en;
        bus.s        = head_word.s;
        bus.b        = head_word.b;
        bus.illegal  = head_word.illegal;
    end

`ifdef CTRL_DECODE_PERF_EN
    // Saturating counters of issued entries and condition-squashed pushes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued   <= '0;
            perf_squashed <= '0;
        end else begin
            if (pop && (perf_issued != '1))
                perf_issued <= perf_issued + 1'b1;
            if (push && !cond_pass && (perf_squashed != '1))
                perf_squashed <= perf_squashed + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Scoreboard bench for ctrl_decode_queue (optionally with CTRL_DECODE_PERF_EN).
module tb_ctrl_decode_queue;
    localparam int TAG_W = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0]       exe_cmd;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             wb_en;
        logic             s;
        logic             b;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_decode_queue_if #(.EXE_CMD_W(4), .TAG_W(TAG_W)) bus ();

`ifdef CTRL_DECODE_PERF_EN
    logic [31:0] perf_issued, perf_squashed;
`endif

    ctrl_decode_queue #(.EXE_CMD_W(4), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CTRL_DECODE_PERF_EN
        ,
        .perf_issued   (perf_issued),
        .perf_squashed (perf_squashed)
`endif
    );

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 0;
    int   issued = 0;
    int   squashed = 0;

    // Pending effect of the inputs driven this cycle, applied at the next edge
    bit   pend_rst = 1, pend_flush = 0, pend_push = 0, pend_sq = 0;
    exp_t pend_entry;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Condition codes come in complementary pairs: cond[0] inverts the base test
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c == 4'hE);
        endcase
        return c[0] ? !base : base;
    endfunction

    // Expected head entry from the instruction-set rules
    function automatic exp_t model(input logic [1:0] md, input logic [3:0] op, input logic si,
                                   input logic [3:0] cd, input logic [3:0] st, input logic [TAG_W-1:0] tg);
        exp_t e;
        int   cmd;
        e = '0;
        e.tag = tg;
        if (md == 2'b00) begin
            case (op)
                4'hD: cmd = 1;  4'hF: cmd = 9;  4'h4: cmd = 2;  4'h5: cmd = 3;
                4'h2: cmd = 4;  4'h6: cmd = 5;  4'h0: cmd = 6;  4'hC: cmd = 7;
                4'h1: cmd = 8;  4'hA: cmd = 4;  4'h8: cmd = 6;
                default: cmd = -1;
            endcase
            if (cmd < 0) e.illegal = 1;
            else begin
                e.exe_cmd = 4'(cmd);
                e.wb_en = !(op == 4'hA || op == 4'h8);
                e.s = si;
            end
        end else if (md == 2'b01) begin
            e.exe_cmd = 4'd2;
            e.mem_r_en = si;
            e.wb_en = si;
            e.mem_w_en = !si;
        end else if (md == 2'b10) begin
            e.b = 1;
        end else begin
            e.illegal = 1;
        end
        if (!cond_ok(cd, st)) begin
            e.exe_cmd = '0; e.mem_r_en = 0; e.mem_w_en = 0; e.wb_en = 0; e.s = 0; e.b = 0;
        end
        return e;
    endfunction

    // Apply last cycle's push/flush/reset to the scoreboard at the clock edge
    task automatic commit();
        if (pend_rst) begin
            exp_q.delete();
            issued = 0;
            squashed = 0;
        end else if (pend_flush) begin
            exp_q.delete();
        end else if (pend_push) begin
            exp_q.push_back(pend_entry);
            if (pend_sq) squashed++;
        end
    endtask

    task automatic cycle(input logic rn, input logic fl, input logic iv, input logic ordy,
                         input logic [1:0] md, input logic [3:0] op, input logic si,
                         input logic [3:0] cd, input logic [3:0] st, input logic [TAG_W-1:0] tg);
        @(posedge clk);
        commit();
        #1;
        rst_n = rn;
        bus.flush = fl;
        bus.in_valid = iv;
        bus.out_ready = ordy;
        bus.mode = md;
        bus.op_code = op;
        bus.s_in = si;
        bus.cond = cd;
        bus.status = st;
        bus.tag_in = tg;
        pend_rst = !rn;
        pend_flush = fl;
        pend_push = rn && !fl && iv && (exp_q.size() < DEPTH || ordy);
        pend_entry = model(md, op, si, cd, st, tg);
        pend_sq = !cond_ok(cd, st);
    endtask

    task automatic idle(input logic ordy);
        cycle(1, 0, 0, ordy, 2'b00, 4'h0, 0, 4'hE, 4'h0, '0);
    endtask

    // Monitor: compare handshake and head entry mid-cycle, retire on pop
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
                check("in_ready", 64'(bus.in_ready),
                      64'(!bus.flush && (exp_q.size() < DEPTH || bus.out_ready)));
                e = (exp_q.size() != 0) ? exp_q[0] : '0;
                got = {bus.exe_cmd, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.s, bus.b,
                       bus.illegal, bus.tag_out};
                check("head", 64'(got), 64'(e));
                if (rst_n && !bus.flush && bus.out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    issued++;
                end
            end
        end
    end

    initial begin
        logic [3:0] cd;
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0; bus.mode = '0; bus.op_code = '0;
        bus.s_in = 0; bus.cond = 4'hE; bus.status = '0; bus.tag_in = '0;
        cycle(0, 0, 0, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, '0);
        mon_en = 1;
        idle(0);
        // ADD with S, consumed immediately
        cycle(1, 0, 1, 1, 2'b00, 4'h4, 1, 4'hE, 4'h0, 32'h1000);
        idle(1);
        // LDR then STR into a stalled queue, then a rejected third push
        cycle(1, 0, 1, 0, 2'b01, 4'h0, 1, 4'hE, 4'h0, 32'h2000);
        cycle(1, 0, 1, 0, 2'b01, 4'h0, 0, 4'hE, 4'h0, 32'h2004);
        cycle(1, 0, 1, 0, 2'b00, 4'hD, 0, 4'hE, 4'h0, 32'hDEAD);
        idle(1);
        idle(1);
        idle(1);
        // Fill, then push and pop together while full
        cycle(1, 0, 1, 0, 2'b00, 4'hC, 0, 4'hE, 4'h0, 32'h3000);
        cycle(1, 0, 1, 0, 2'b00, 4'h1, 1, 4'hE, 4'h0, 32'h3004);
        for (int i = 0; i < 4; i++)
            cycle(1, 0, 1, 1, 2'b10, 4'h0, 0, 4'hE, 4'h0, 32'h3100 + 32'(i));
        idle(1); idle(1); idle(1);
        // EQ failing then passing
        cycle(1, 0, 1, 1, 2'b00, 4'h4, 1, 4'h0, 4'h0, 32'h4000);
        cycle(1, 0, 1, 1, 2'b00, 4'h4, 1, 4'h0, 4'h4, 32'h4004);
        // Undefined encodings
        cycle(1, 0, 1, 1, 2'b11, 4'h4, 1, 4'hE, 4'h0, 32'h5000);
        cycle(1, 0, 1, 1, 2'b00, 4'h3, 1, 4'hE, 4'h0, 32'h5004);
        idle(1);
        // Flush a full queue with a concurrent input
        cycle(1, 0, 1, 0, 2'b00, 4'h5, 0, 4'hE, 4'h0, 32'h6000);
        cycle(1, 0, 1, 0, 2'b00, 4'h6, 0, 4'hE, 4'h0, 32'h6004);
        cycle(1, 1, 1, 1, 2'b00, 4'hF, 0, 4'hE, 4'h0, 32'h6008);
        idle(0); idle(1);
        // Reset with a non-empty queue
        cycle(1, 0, 1, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 32'h7000);
        cycle(1, 0, 1, 0, 2'b00, 4'h8, 1, 4'hE, 4'h0, 32'h7004);
        cycle(0, 0, 1, 1, 2'b00, 4'h2, 0, 4'hE, 4'h0, 32'h7008);
        idle(0); idle(1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cd = ($urandom_range(1) == 0) ? 4'hE : 4'($urandom_range(15));
            cycle($urandom_range(63) != 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
                  $urandom_range(2) != 0, 2'($urandom_range(3)), 4'($urandom_range(15)),
                  1'($urandom_range(1)), cd, 4'($urandom_range(15)), $urandom);
        end
        idle(1); idle(1); idle(1);
        @(posedge clk);
        commit();
        @(negedge clk);
        #1;
`ifdef CTRL_DECODE_PERF_EN
        check("perf_issued", 64'(perf_issued), 64'(issued));
        check("perf_squashed", 64'(perf_squashed), 64'(squashed));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
